mips_cpu: RTL and testbench
===========================

// Module: mips_cpu
// PURPOSE
// - Single-cycle 32-bit MIPS subset CPU: fetch, decode, execute, memory access and writeback all in one clk.
// - Top level of the core; the bench preloads instruction memory via $readmemh into U_IM.imem.
// - The bench inspects PC, AnInstruction, U_RF.rf[] and U_DM.dataMem[] hierarchically.
// PARAMETERS
// - IMEM_WORDS  128  instruction memory depth in 32-bit words (U_IM.imem[0:IMEM_WORDS-1]).
// - DMEM_WORDS  128  data memory depth in 32-bit words (U_DM.dataMem[0:DMEM_WORDS-1]).
// - RESET_PC    0    byte address loaded into PC on reset.
// PORTS
// - clk  input  1  clock; all state updates on the rising edge.
// - rst  input  1  reset, asynchronous, active-low.
// BEHAVIOUR
// - Required internals (names fixed):
//   - PC: 32-bit register.
//   - AnInstruction: 32-bit wire = U_IM.imem[PC[31:2]].
//   - U_RF.rf[0:31]: register file.
//   - U_DM.dataMem: data memory, word-indexed by addr[31:2].
// - Reset (rst=0): PC <= RESET_PC and rf[1..31] <= 0, immediately.
//   - Memories are not cleared.
// - Each cycle executes exactly one instruction, so CPI=1.
// - Instruction and data memory reads are combinational; writes commit at posedge.
// - rf: two combinational read ports and one write port at posedge. Register $0 always reads 0; writes to it are ignored.
// - R-type (op=0), by funct:
//   - add 0x20, sub 0x22: wrap-around, no overflow trap.
//   - and 0x24, or 0x25.
//   - slt 0x2A: signed compare, result 1 or 0.
//   - Destination is rd.
// - I-type, destination rt:
//   - addi 0x08, slti 0x0A: sign-extended imm.
//   - andi 0x0C, ori 0x0D: zero-extended imm.
//   - lui 0x0F: rt = {imm,16'h0}.
// - lw 0x23 / sw 0x2B: addr = rs + sext(imm).
//   - Addresses are word aligned; low 2 bits ignored.
//   - Out-of-range index: lw returns 0, sw is dropped.
// - beq 0x04 / bne 0x05: taken target = PC+4 + (sext(imm)<<2); otherwise PC+4.
// - j 0x02: PC = {PC+4[31:28], target, 2'b00}.
// - No branch delay slot. PC wraps modulo 2^32.
// - Any undefined opcode or funct executes as a NOP: PC+4, no register or memory write.
// - sw into a location that a lw reads in the same cycle is impossible, since there is one memory op per cycle.
// - Writeback mux, in priority order: memory (lw), link (jal), lui, ALU.
// CONFIGURATION
// - Macro MIPS_JAL_JR_EN.
// - When defined:
//   - jal (op 0x03) writes PC+4 to rf[31] and jumps like j.
//   - jr (op 0, funct 0x08) sets PC = rs with no register write.
// - When undefined, both execute as NOPs.
// TESTING
// - Reset: hold rst=0, load imem.
//   - Expect PC=0x00000000 and AnInstruction=imem[0].
//   - Release rst; PC steps 0,4,8 on successive rising edges for non-branch code.
// - ALU program: addi $2,$0,5; addi $3,$0,12; sub $4,$3,$2; or $5,$2,$3; slt $6,$2,$3; and $7,$3,$4.
//   - Expect rf[2]=5, rf[3]=12, rf[4]=7, rf[5]=13, rf[6]=1, rf[7]=4.
// - Memory: addi $2,$0,7; sw $2,84($0); lw $3,84($0); sw $3,80($0).
//   - Expect dataMem[21]=7, dataMem[20]=7, rf[3]=7.
// - Loop: addi $1,$0,3; loop: addi $1,$1,-1; bne $1,$0,loop; sw $1,80($0); j self.
//   - Expect rf[1]=0 and dataMem[20]=0.
//   - PC then holds constant at the j address; run 40 cycles.
// - $0 and lui: addi $0,$0,9; lui $8,0x1234; ori $8,$8,0x5678.
//   - Expect rf[0]=0 and rf[8]=0x12345678.
// - MIPS_JAL_JR_EN: jal sub at PC 0x10, where sub: addi $9,$0,1; jr $31.
//   - Expect rf[31]=0x14, rf[9]=1, and execution resumes at 0x14.
//   - Without the macro: rf[31]=0.

Source files
------------

// File: rtl/mips_cpu.sv
// Single-cycle 32-bit MIPS subset core: fetch, decode, execute, memory access
// and writeback all complete in one clock.
// Optional feature: define MIPS_JAL_JR_EN to enable jal/jr; otherwise both
// decode as NOPs.

// Instruction memory: combinational word read, out-of-range fetches read as 0.
module mips_imem #(
    parameter int unsigned WORDS = 128
) (
    input  logic [31:0] addr,
    output logic [31:0] instr
);
    localparam int unsigned AW    = $clog2(WORDS);
    localparam logic [29:0] LIMIT = 30'(WORDS);

    logic [31:0] imem [0:WORDS-1];
    logic        unused_lo;

    // Word-indexed combinational fetch
    always_comb begin
        unused_lo = ^addr[1:0];
        instr     = (addr[31:2] < LIMIT) ? imem[addr[AW+1:2]] : '0;
    end
endmodule

// Register file: two combinational read ports, one posedge write port, $0 hardwired.
module mips_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] rf [0:31];

    // Asynchronous clear, then single write port ignoring $0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
        end else if (we && wa != 5'd0) begin
            rf[wa] <= wd;
        end
    end

    // Combinational reads, $0 forced to zero
    always_comb begin
        rd1 = (ra1 == 5'd0) ? '0 : rf[ra1];
        rd2 = (ra2 == 5'd0) ? '0 : rf[ra2];
    end
endmodule

// Data memory: combinational read, posedge write; out-of-range reads 0, writes dropped.
module mips_dmem #(
    parameter int unsigned WORDS = 128
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd
);
    localparam int unsigned AW    = $clog2(WORDS);
    localparam logic [29:0] LIMIT = 30'(WORDS);

    logic [31:0]   dataMem [0:WORDS-1];
    logic          in_range;
    logic [AW-1:0] idx;
    logic          unused_lo;

    // Range check and combinational read
    always_comb begin
        unused_lo = ^addr[1:0];
        in_range  = (addr[31:2] < LIMIT);
        idx       = addr[AW+1:2];
        rd        = in_range ? dataMem[idx] : '0;
    end

    // Store commit, dropped when out of range
    always_ff @(posedge clk) begin
        if (we && in_range) dataMem[idx] <= wd;
    end
endmodule

module mips_cpu #(
    parameter int unsigned IMEM_WORDS = 128,
    parameter int unsigned DMEM_WORDS = 128,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_SLT    = 6'h2A;
`ifdef MIPS_JAL_JR_EN
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] F_JR     = 6'h08;
`endif

    logic [31:0] PC;
    logic [31:0] AnInstruction;
    logic [31:0] next_pc, pc4, jump_pc, branch_pc;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wa;
    logic [15:0] imm;
    logic [31:0] simm, zimm;
    logic [31:0] rs_val, rt_val, alu_res, wb_data, dm_rd, dm_addr;
    logic        reg_we, mem_we, sel_mem, sel_link, sel_lui;
    logic        unused_shamt;

    mips_imem #(.WORDS(IMEM_WORDS)) U_IM (
        .addr  (PC),
        .instr (AnInstruction)
    );

    mips_regfile U_RF (
        .clk (clk),
        .rst (rst),
        .ra1 (rs),
        .ra2 (rt),
        .we  (reg_we),
        .wa  (wa),
        .wd  (wb_data),
        .rd1 (rs_val),
        .rd2 (rt_val)
    );

    // Stores are suppressed while reset is held so a sw at RESET_PC cannot
    // repeatedly hit memory before the core starts.
    mips_dmem #(.WORDS(DMEM_WORDS)) U_DM (
        .clk  (clk),
        .we   (mem_we & rst),
        .addr (dm_addr),
        .wd   (rt_val),
        .rd   (dm_rd)
    );

    // Field extraction and address arithmetic
    always_comb begin
        op           = AnInstruction[31:26];
        rs           = AnInstruction[25:21];
        rt           = AnInstruction[20:16];
        rd           = AnInstruction[15:11];
        funct        = AnInstruction[5:0];
        imm          = AnInstruction[15:0];
        unused_shamt = ^AnInstruction[10:6];
        simm         = {{16{imm[15]}}, imm};
        zimm         = {16'h0000, imm};
        pc4          = PC + 32'd4;
        branch_pc    = pc4 + {simm[29:0], 2'b00};
        jump_pc      = {pc4[31:28], AnInstruction[25:0], 2'b00};
        dm_addr      = rs_val + simm;
    end

    // Decode, ALU and next-PC selection; anything unrecognised is a NOP
    always_comb begin
        next_pc  = pc4;
        reg_we   = 1'b0;
        wa       = rt;
        alu_res  = '0;
        mem_we   = 1'b0;
        sel_mem  = 1'b0;
        sel_link = 1'b0;
        sel_lui  = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD: begin reg_we = 1'b1; wa = rd; alu_res = rs_val + rt_val; end
                    F_SUB: begin reg_we = 1'b1; wa = rd; alu_res = rs_val - rt_val; end
                    F_AND: begin reg_we = 1'b1; wa = rd; alu_res = rs_val & rt_val; end
                    F_OR:  begin reg_we = 1'b1; wa = rd; alu_res = rs_val | rt_val; end
                    F_SLT: begin
                        reg_we  = 1'b1;
                        wa      = rd;
                        alu_res = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0;
                    end
`ifdef MIPS_JAL_JR_EN
                    F_JR:  next_pc = rs_val;
`endif
                    default: ;
                endcase
            end
            OP_ADDI: begin reg_we = 1'b1; alu_res = rs_val + simm; end
            OP_SLTI: begin
                reg_we  = 1'b1;
                alu_res = ($signed(rs_val) < $signed(simm)) ? 32'd1 : 32'd0;
            end
            OP_ANDI: begin reg_we = 1'b1; alu_res = rs_val & zimm; end
            OP_ORI:  begin reg_we = 1'b1; alu_res = rs_val | zimm; end
            OP_LUI:  begin reg_we = 1'b1; sel_lui = 1'b1; end
            OP_LW:   begin reg_we = 1'b1; sel_mem = 1'b1; end
            OP_SW:   mem_we = 1'b1;
            OP_BEQ:  if (rs_val == rt_val) next_pc = branch_pc;
            OP_BNE:  if (rs_val != rt_val) next_pc = branch_pc;
            OP_J:    next_pc = jump_pc;
`ifdef MIPS_JAL_JR_EN
            OP_JAL:  begin reg_we = 1'b1; wa = 5'd31; sel_link = 1'b1; next_pc = jump_pc; end
`endif
            default: ;
        endcase
    end

    // Writeback source in priority order: memory, link, lui, ALU
    always_comb begin
        if (sel_mem)       wb_data = dm_rd;
        else if (sel_link) wb_data = pc4;
        else if (sel_lui)  wb_data = {imm, 16'h0000};
        else               wb_data = alu_res;
    end

    // Program counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) PC <= RESET_PC;
        else      PC <= next_pc;
    end
endmodule

// File: tb/tb_mips_cpu.sv
// Self-checking bench for mips_cpu: directed programs plus random programs,
// compared against an instruction-level interpreter of the ISA.
module tb_mips_cpu;
    localparam int unsigned NW = 128;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] prog [0:NW-1];
    logic [31:0] mr   [0:31];
    logic [31:0] mm   [0:NW-1];
    logic [31:0] mpc;

    always #5 clk = ~clk;

    mips_cpu #(.IMEM_WORDS(NW), .DMEM_WORDS(NW), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] s,
                                          input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'h00, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tg);
        return {op, tg};
    endfunction

    // Interpreter: executes one instruction at mpc against mr/mm
    task automatic model_step();
        logic [31:0] ins, a, b, pc4, se, addr, nxt;
        int unsigned w;
        ins  = 32'h0;
        w    = mpc >> 2;
        if (w < NW) ins = prog[w];
        a    = mr[ins[25:21]];
        b    = mr[ins[20:16]];
        pc4  = mpc + 32'd4;
        se   = {{16{ins[15]}}, ins[15:0]};
        addr = a + se;
        w    = addr >> 2;
        nxt  = pc4;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: mr[ins[15:11]] = a + b;
                6'h22: mr[ins[15:11]] = a - b;
                6'h24: mr[ins[15:11]] = a & b;
                6'h25: mr[ins[15:11]] = a | b;
                6'h2A: mr[ins[15:11]] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef MIPS_JAL_JR_EN
                6'h08: nxt = a;
`endif
                default: ;
            endcase
            6'h08: mr[ins[20:16]] = a + se;
            6'h0A: mr[ins[20:16]] = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
            6'h0C: mr[ins[20:16]] = a & {16'h0, ins[15:0]};
            6'h0D: mr[ins[20:16]] = a | {16'h0, ins[15:0]};
            6'h0F: mr[ins[20:16]] = {ins[15:0], 16'h0};
            6'h23: mr[ins[20:16]] = (w < NW) ? mm[w] : 32'h0;
            6'h2B: if (w < NW) mm[w] = b;
            6'h04: if (a == b) nxt = pc4 + (se << 2);
            6'h05: if (a != b) nxt = pc4 + (se << 2);
            6'h02: nxt = {pc4[31:28], ins[25:0], 2'b00};
`ifdef MIPS_JAL_JR_EN
            6'h03: begin mr[31] = pc4; nxt = {pc4[31:28], ins[25:0], 2'b00}; end
`endif
            default: ;
        endcase
        mr[0] = 32'h0;
        mpc   = nxt;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < NW; i++) prog[i] = 32'h0;
    endtask

    // Hold reset, load memories, check reset state, release on a falling edge
    task automatic start_prog();
        rst = 1'b0;
        for (int i = 0; i < NW; i++) begin
            dut.U_IM.imem[i]    = prog[i];
            mm[i]               = {16'hA5A5, 16'(i)};
            dut.U_DM.dataMem[i] = mm[i];
        end
        for (int i = 0; i < 32; i++) mr[i] = 32'h0;
        mpc = 32'h0;
        @(posedge clk);
        #1;
        check("reset_pc", dut.PC, 32'h0);
        check("reset_instr", dut.AnInstruction, prog[0]);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned c = 0; c < n; c++) begin
            model_step();
            @(posedge clk);
            #1;
            check("pc", dut.PC, mpc);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 32; i++) check($sformatf("rf[%0d]", i), dut.U_RF.rf[i], mr[i]);
        for (int i = 0; i < NW; i++) check($sformatf("dm[%0d]", i), dut.U_DM.dataMem[i], mm[i]);
    endtask

    task automatic gen_random(input int unsigned n);
        logic [4:0]  s, t, d;
        logic [15:0] im;
        int          tg;
        clear_prog();
        for (int i = 0; i < int'(n) - 1; i++) begin
            s  = 5'($urandom_range(0, 7));
            t  = 5'($urandom_range(0, 7));
            d  = 5'($urandom_range(1, 7));
            im = 16'($urandom);
            tg = int'($urandom_range(0, n - 1));
            case ($urandom_range(0, 15))
                0:  prog[i] = enc_r(6'h20, s, t, d);
                1:  prog[i] = enc_r(6'h22, s, t, d);
                2:  prog[i] = enc_r(6'h24, s, t, d);
                3:  prog[i] = enc_r(6'h25, s, t, d);
                4:  prog[i] = enc_r(6'h2A, s, t, d);
                5:  prog[i] = enc_i(6'h08, s, d, im);
                6:  prog[i] = enc_i(6'h0A, s, d, im);
                7:  prog[i] = enc_i(6'h0C, s, d, im);
                8:  prog[i] = enc_i(6'h0D, s, d, im);
                9:  prog[i] = enc_i(6'h0F, s, d, im);
                10: prog[i] = enc_i(6'h23, ($urandom_range(0, 3) == 0) ? s : 5'd0, d,
                                    16'($urandom_range(0, 140) * 4 + $urandom_range(0, 3)));
                11: prog[i] = enc_i(6'h2B, ($urandom_range(0, 3) == 0) ? s : 5'd0, t,
                                    16'($urandom_range(0, 140) * 4));
                12: prog[i] = enc_i(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, s, t,
                                    16'(tg - (i + 1)));
                13: prog[i] = enc_j(($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03, 26'(tg));
                14: prog[i] = ($urandom_range(0, 1) == 0) ? enc_i(6'h3F, s, d, im)
                                                          : enc_r(6'h3F, s, t, d);
                default: prog[i] = enc_r(6'h08, 5'd31, 5'd0, 5'd0);
            endcase
        end
        prog[n-1] = enc_j(6'h02, 26'(n - 1));
    endtask

    initial begin
        // ALU program
        clear_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd2, 16'd5);
        prog[1] = enc_i(6'h08, 5'd0, 5'd3, 16'd12);
        prog[2] = enc_r(6'h22, 5'd3, 5'd2, 5'd4);
        prog[3] = enc_r(6'h25, 5'd2, 5'd3, 5'd5);
        prog[4] = enc_r(6'h2A, 5'd2, 5'd3, 5'd6);
        prog[5] = enc_r(6'h24, 5'd3, 5'd4, 5'd7);
        start_prog();
        run(8);
        check("alu_r2", dut.U_RF.rf[2], 32'd5);
        check("alu_r3", dut.U_RF.rf[3], 32'd12);
        check("alu_r4", dut.U_RF.rf[4], 32'd7);
        check("alu_r5", dut.U_RF.rf[5], 32'd13);
        check("alu_r6", dut.U_RF.rf[6], 32'd1);
        check("alu_r7", dut.U_RF.rf[7], 32'd4);
        compare_all();
        // Reset must act mid-cycle, without waiting for a clock edge
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("async_pc", dut.PC, 32'h0);
        check("async_rf2", dut.U_RF.rf[2], 32'h0);

        // Memory program
        clear_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
        prog[1] = enc_i(6'h2B, 5'd0, 5'd2, 16'd84);
        prog[2] = enc_i(6'h23, 5'd0, 5'd3, 16'd84);
        prog[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'd80);
        start_prog();
        run(6);
        check("mem_dm21", dut.U_DM.dataMem[21], 32'd7);
        check("mem_dm20", dut.U_DM.dataMem[20], 32'd7);
        check("mem_r3", dut.U_RF.rf[3], 32'd7);
        compare_all();

        // Counted loop ending in a self-jump
        clear_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
        prog[1] = enc_i(6'h08, 5'd1, 5'd1, 16'hFFFF);
        prog[2] = enc_i(6'h05, 5'd1, 5'd0, 16'hFFFE);
        prog[3] = enc_i(6'h2B, 5'd0, 5'd1, 16'd80);
        prog[4] = enc_j(6'h02, 26'd4);
        start_prog();
        run(40);
        check("loop_r1", dut.U_RF.rf[1], 32'd0);
        check("loop_dm20", dut.U_DM.dataMem[20], 32'd0);
        check("loop_pc", dut.PC, 32'h10);
        compare_all();

        // $0 stays zero; lui/ori build a constant
        clear_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
        prog[1] = enc_i(6'h0F, 5'd0, 5'd8, 16'h1234);
        prog[2] = enc_i(6'h0D, 5'd8, 5'd8, 16'h5678);
        start_prog();
        run(5);
        check("zero_r0", dut.U_RF.rf[0], 32'h0);
        check("lui_r8", dut.U_RF.rf[8], 32'h1234_5678);
        compare_all();

        // jal to a subroutine that returns with jr $31
        clear_prog();
        prog[4]  = enc_j(6'h03, 26'd8);
        prog[5]  = enc_i(6'h2B, 5'd0, 5'd9, 16'd80);
        prog[6]  = enc_j(6'h02, 26'd6);
        prog[8]  = enc_i(6'h08, 5'd0, 5'd9, 16'd1);
        prog[9]  = enc_r(6'h08, 5'd31, 5'd0, 5'd0);
        start_prog();
        run(12);
`ifdef MIPS_JAL_JR_EN
        check("jal_r31", dut.U_RF.rf[31], 32'h14);
        check("jal_r9", dut.U_RF.rf[9], 32'd1);
        check("jal_dm20", dut.U_DM.dataMem[20], 32'd1);
`else
        check("nojal_r31", dut.U_RF.rf[31], 32'h0);
        check("nojal_r9", dut.U_RF.rf[9], 32'h0);
`endif
        check("jal_pc", dut.PC, 32'h18);
        compare_all();

        // Random programs against the interpreter
        for (int p = 0; p < 6; p++) begin
            gen_random(48);
            start_prog();
            run(200);
            compare_all();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
